// File: rtl/dm_byte_cache.sv
// Direct-mapped, byte-addressed, write-through / no-write-allocate cache with a
// byte-serial refill engine and saturating hit/miss counters.
module dm_byte_cache #(
   parameter int ADDR_W     = 16,
   parameter int LINE_BYTES = 32,
   parameter int NUM_LINES  = 8,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ready,
   output logic              cpu_done,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_hit,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count,
   output logic [1:0]        dbg_state
);

   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

   // Handshake: a CPU request transfers on a rising edge where cpu_req && cpu_ready;
   // a memory access is offered while mem_req is high and completes on the edge
   // where mem_ack is high. Neither side queues; an unaccepted cpu_req is dropped.
   typedef enum logic [1:0] {IDLE, REFILL, WRMEM, RESP} state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0]   addr_q;
   logic                we_q;
   logic [7:0]          wdata_q;
   logic                hit_q;
   logic [OFF_W-1:0]    k_q;
   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]    tag_q  [NUM_LINES];
   logic [7:0]          data_q [NUM_LINES*LINE_BYTES];
   logic                done_q, chit_q;
   logic [7:0]          rdata_q;
   logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;

   logic [TAG_W-1:0] req_tag, lat_tag;
   logic [IDX_W-1:0] req_idx, lat_idx;
   logic [OFF_W-1:0] req_off, lat_off;
   logic             lookup_hit, accept, refill_ack, refill_last;

   assign req_tag = cpu_addr[ADDR_W-1 -: TAG_W];
   assign req_idx = cpu_addr[OFF_W +: IDX_W];
   assign req_off = cpu_addr[OFF_W-1:0];
   assign lat_tag = addr_q[ADDR_W-1 -: TAG_W];
   assign lat_idx = addr_q[OFF_W +: IDX_W];
   assign lat_off = addr_q[OFF_W-1:0];

   assign cpu_ready   = (state_q == IDLE) && !rst;
   assign accept      = cpu_req && cpu_ready;
   assign lookup_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign refill_ack  = (state_q == REFILL) && mem_ack;
   assign refill_last = refill_ack && (&k_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (cpu_we)          state_d = WRMEM;
               else if (lookup_hit) state_d = RESP;
               else                 state_d = REFILL;
            end
         end
         REFILL:  if (refill_last) state_d = RESP;
         WRMEM:   if (mem_ack) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         hit_q      <= 1'b0;
         k_q        <= '0;
         valid_q    <= '0;
         done_q     <= 1'b0;
         chit_q     <= 1'b0;
         rdata_q    <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == RESP);
         chit_q  <= (state_q == RESP) && hit_q;
         if (accept) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            hit_q   <= lookup_hit;
            k_q     <= '0;
            if (lookup_hit) begin
               if (~&hit_cnt_q) hit_cnt_q <= hit_cnt_q + 1'b1;
            end else begin
               if (~&miss_cnt_q) miss_cnt_q <= miss_cnt_q + 1'b1;
            end
            // The victim line stays invalid until its last byte has arrived.
            if (!cpu_we && !lookup_hit) valid_q[req_idx] <= 1'b0;
         end
         if (refill_ack) k_q <= k_q + 1'b1;
         if (refill_last) valid_q[lat_idx] <= 1'b1;
         if (state_q == RESP && !we_q) rdata_q <= data_q[{lat_idx, lat_off}];
      end
   end

   // Tag and data storage carry no reset; the valid bits guard them.
   always_ff @(posedge clk) begin
      if (accept && cpu_we && lookup_hit) data_q[{req_idx, req_off}] <= cpu_wdata;
      else if (refill_ack) data_q[{lat_idx, k_q}] <= mem_rdata;
      if (refill_last) tag_q[lat_idx] <= lat_tag;
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state_q == REFILL) begin
         mem_req  = 1'b1;
         mem_addr = {addr_q[ADDR_W-1:OFF_W], k_q};
      end else if (state_q == WRMEM) begin
         mem_req   = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = addr_q;
         mem_wdata = wdata_q;
      end
   end

   assign cpu_done   = done_q;
   assign cpu_hit    = chit_q;
   assign cpu_rdata  = rdata_q;
   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_dm_byte_cache.sv
// Scoreboard bench for dm_byte_cache: stimulus pushes expected CPU responses and
// memory accesses; a CPU monitor and a memory responder pop and compare them.
module tb_dm_byte_cache;

   logic        clk, rst;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ready, cpu_done, cpu_hit;
   logic [7:0]  cpu_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic [15:0] hit_count, miss_count;
   logic [1:0]  dbg_state;

   dm_byte_cache dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_count(hit_count), .miss_count(miss_count), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int accept_cyc = 0;

   // {we, hit, rdata}
   logic [9:0]  exp_q[$];
   // {we, addr, wdata}
   logic [24:0] exp_mem_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- CPU monitor ----------------
   initial begin
      logic [9:0] e;
      forever begin
         @(negedge clk);
         if (!rst && cpu_done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("cpu_hit", {31'd0, cpu_hit}, {31'd0, e[8]});
               if (!e[9]) begin
                  chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e[7:0]});
                  if (e[8]) chk("hit_latency", cyc - accept_cyc, 32'd1);
               end
            end
         end
      end
   end

   // ---------------- memory responder ----------------
   initial begin
      int delay;
      logic [24:0] e;
      delay = -1;
      mem_ack = 1'b0;
      mem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            mem_ack = 1'b0;
            delay = -1;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
            delay = -1;
         end else if (mem_req) begin
            if (delay < 0) delay = $urandom_range(0, 3);
            if (delay == 0) begin
               if (exp_mem_q.size() == 0) begin
                  chk("unexpected_mem", {15'd0, mem_we, mem_addr}, 32'd0);
               end else begin
                  e = exp_mem_q.pop_front();
                  chk("mem_access", {7'd0, mem_we, mem_addr, mem_we ? mem_wdata : 8'h00},
                      {7'd0, e});
               end
               mem_rdata = mem_addr[7:0] ^ 8'h5A;
               mem_ack = 1'b1;
               delay = -1;
            end else begin
               delay--;
            end
         end else begin
            delay = -1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue_req(input logic [15:0] a, input logic we, input logic [7:0] wd,
                            input logic exp_hit, input logic [7:0] exp_rd);
      int n;
      n = 0;
      @(negedge clk);
      while (!cpu_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cpu_ready) chk("ready_timeout", 32'd0, 32'd1);
      if (we) begin
         exp_mem_q.push_back({1'b1, a, wd});
      end else if (!exp_hit) begin
         for (int k = 0; k < 32; k++) exp_mem_q.push_back({1'b0, a[15:5], k[4:0], 8'h00});
      end
      exp_q.push_back({we, exp_hit, exp_rd});
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = wd;
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = 16'h0000;
      cpu_wdata = 8'h00;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || cpu_done) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("done_timeout", exp_q.size(), 32'd0);
         exp_q.delete();
      end
   endtask

   task automatic do_req(input logic [15:0] a, input logic we, input logic [7:0] wd,
                         input logic exp_hit, input logic [7:0] exp_rd);
      issue_req(a, we, wd, exp_hit, exp_rd);
      wait_done();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst = 1'b1;
      cpu_req = 1'b0;
      cpu_we = 1'b0;
      cpu_addr = 16'h0000;
      cpu_wdata = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
      chk("rst_done", {31'd0, cpu_done}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
      chk("rst_counts", {hit_count, miss_count}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, cpu_ready}, 32'd1);

      // cold miss, then hit in the same line
      do_req(16'h0123, 1'b0, 8'h00, 1'b0, 8'h79);
      chk("miss_count_1", {16'd0, miss_count}, 32'd1);
      do_req(16'h0125, 1'b0, 8'h00, 1'b1, 8'h7F);
      chk("hit_count_1", {16'd0, hit_count}, 32'd1);

      // write hit goes through to memory and updates the line
      do_req(16'h0125, 1'b1, 8'hAB, 1'b1, 8'h00);
      do_req(16'h0125, 1'b0, 8'h00, 1'b1, 8'hAB);
      chk("hit_count_3", {16'd0, hit_count}, 32'd3);

      // conflict at index 1 evicts tag 1
      do_req(16'h0223, 1'b0, 8'h00, 1'b0, 8'h79);
      do_req(16'h0123, 1'b0, 8'h00, 1'b0, 8'h79);

      // write miss does not allocate
      do_req(16'h0400, 1'b1, 8'h11, 1'b0, 8'h00);
      do_req(16'h0400, 1'b0, 8'h00, 1'b0, 8'h5A);
      chk("hit_count_end", {16'd0, hit_count}, 32'd3);
      chk("miss_count_end", {16'd0, miss_count}, 32'd5);

      // reset in the middle of a refill
      issue_req(16'h0300, 1'b0, 8'h00, 1'b0, 8'h5A);
      n = 0;
      while (!(mem_req && mem_addr == 16'h030A) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("reach_k10", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h030A});
      rst = 1'b1;
      #1;
      chk("rst_drops_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mid_counts", {hit_count, miss_count}, 32'd0);
      exp_q.delete();
      exp_mem_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("no_done_after_rst", {31'd0, cpu_done}, 32'd0);
      do_req(16'h0300, 1'b0, 8'h00, 1'b0, 8'h5A);
      chk("miss_count_rerefill", {16'd0, miss_count}, 32'd1);
      do_req(16'h030A, 1'b0, 8'h00, 1'b1, 8'h50);

      repeat (5) @(negedge clk);
      chk("exp_q_empty", exp_q.size(), 32'd0);
      chk("exp_mem_q_empty", exp_mem_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
